// File: rtl/mem_sram_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// State enum, default data base address, half-select constants.
package mem_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    DONE
  } state_t;

  localparam int unsigned DATA_BASE_DEF = 1024;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing each SRAM half access.
// Ports: clk, rst (sync active-low), i_load, o_last (count is zero).
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last
);

  localparam int unsigned CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_V = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_V;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: 32-bit load/store as two 16-bit async SRAM
// accesses, freezing the pipeline via ready until done.
// Ports: clk, rst (sync active-low), rd_en, wr_en, address, write_data,
//   read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in,
//   sram_we_n; align_err only with MEM_SRAM_ALIGN_CHECK_EN defined.
module mem_sram_ctrl
  import mem_sram_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DATA_BASE   = DATA_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
`ifdef MEM_SRAM_ALIGN_CHECK_EN
  output logic                   align_err,
`endif
  output logic                   sram_we_n
);

  localparam logic [31:0] BASE = 32'(DATA_BASE);

  state_t r_state;
  state_t w_next;

  logic                   r_wr;
  logic [SRAM_ADDR_W-2:0] r_word;
  logic [31:0]            r_wdata;

  logic                   w_req;
  logic                   w_load;
  logic                   w_last;
  logic [31:0]            w_off;
  logic [SRAM_ADDR_W-2:0] w_word;
  logic                   w_unused;

  assign w_req    = rd_en | wr_en;
  assign w_off    = address - BASE;
  assign w_word   = w_off[SRAM_ADDR_W:2];
  assign w_unused = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};

  assign ready = ~w_req | (r_state == DONE);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = ACC_LO;
          w_load = 1'b1;
        end
      end
      ACC_LO: begin
        if (w_last) begin
          w_next = ACC_HI;
          w_load = 1'b1;
        end
      end
      ACC_HI: begin
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pins are registered and set up on the edge that enters each phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr        <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_wr        <= wr_en;
            r_word      <= w_word;
            r_wdata     <= write_data;
            sram_addr   <= {w_word, LO};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        ACC_LO: begin
          if (w_last) begin
            if (!r_wr) read_data[15:0] <= sram_dq_in;
            sram_addr   <= {r_word, HI};
            sram_dq_out <= r_wdata[31:16];
            // Strobe gap at the half boundary unless there is no room.
            sram_we_n   <= (WAIT_CYCLES > 1) ? 1'b1 : ~r_wr;
          end
        end
        ACC_HI: begin
          if (w_last) begin
            if (!r_wr) read_data[31:16] <= sram_dq_in;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            sram_we_n  <= ~r_wr;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_SRAM_ALIGN_CHECK_EN
  logic r_align;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_align <= 1'b0;
    end else if (r_state == IDLE && w_req &&
                 (address[1:0] != 2'b00 || address < BASE)) begin
      r_align <= 1'b1;
    end
  end

  assign align_err = r_align;
`endif

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl with a behavioural async SRAM.
// Directed loads/stores, idle, back-to-back, mid-access reset.
module tb_mem_sram_ctrl;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  logic        mem_clr = 1'b1;
  logic [15:0] mem [0:255];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   c0 = 0;
  exp_t sbq[$];
  exp_t mon_e;

  mem_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
`ifdef MEM_SRAM_ALIGN_CHECK_EN
    .align_err  (align_err),
`endif
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Call at #1 after a rising edge; that cycle is cycle 0.
  task automatic issue(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd);
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
    sbq.push_back('{rd: rd & ~wr, data: exp_rd, cyc: cyc + 5});
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: ready never rose at %0d", cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && (rd_en || wr_en) && ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: cycle %0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.rd) chk("read_data", read_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
`ifdef MEM_SRAM_ALIGN_CHECK_EN
    chk("rst_align", 32'(align_err), 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk);
    #1;

    // Store with pin trace
    issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    chk("st_c0_ready", 32'(ready), 32'h0);
    @(negedge clk);
    chk("st_c1_addr", 32'(sram_addr), 32'd2);
    chk("st_c1_we_n", 32'(sram_we_n), 32'h0);
    chk("st_c1_oe", 32'(sram_dq_oe), 32'h1);
    chk("st_c1_dq", 32'(sram_dq_out), 32'hBEEF);
    @(negedge clk);
    chk("st_c2_ready", 32'(ready), 32'h0);
    @(negedge clk);
    chk("st_c3_addr", 32'(sram_addr), 32'd3);
    chk("st_c3_we_n", 32'(sram_we_n), 32'h1);
    @(negedge clk);
    chk("st_c4_we_n", 32'(sram_we_n), 32'h0);
    chk("st_c4_dq", 32'(sram_dq_out), 32'hDEAD);
    chk("st_c4_ready", 32'(ready), 32'h0);
    wait_done();
    idle();
    chk("mem2", 32'(mem[2]), 32'hBEEF);
    chk("mem3", 32'(mem[3]), 32'hDEAD);

    // Load back
    issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF);
    wait_done();
    idle();
    chk("ld_hold", read_data, 32'hDEADBEEF);

    // Idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'h1);
      chk("idle_we_n", 32'(sram_we_n), 32'h1);
      chk("idle_oe", 32'(sram_dq_oe), 32'h0);
      chk("idle_rdata", read_data, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1;

    // Back-to-back store then load
    c0 = cyc;
    issue(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'h0);
    wait_done();
    issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678);
    wait_done();
    idle();
    chk("b2b_total", 32'(cyc - c0), 32'd12);
    chk("mem0", 32'(mem[0]), 32'h5678);
    chk("mem1", 32'(mem[1]), 32'h1234);

    // Both enables: write wins, read_data untouched
    issue(1'b1, 1'b1, 32'd1040, 32'h0BADF00D, 32'h0);
    wait_done();
    idle();
    chk("both_mem8", 32'(mem[8]), 32'hF00D);
    chk("both_mem9", 32'(mem[9]), 32'h0BAD);
    chk("both_rdata", read_data, 32'h12345678);

    // Below base wraps to top of SRAM
    issue(1'b0, 1'b1, 32'd1020, 32'hCAFE0001, 32'h0);
    wait_done();
    idle();
    chk("wrap_lo", 32'(mem[8'hFE]), 32'h0001);
    chk("wrap_hi", 32'(mem[8'hFF]), 32'hCAFE);
    issue(1'b1, 1'b0, 32'd1020, 32'h0, 32'hCAFE0001);
    wait_done();
    idle();

    // Reset during ACC_HI of a store
    issue(1'b0, 1'b1, 32'd1032, 32'hAABBCCDD, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    sbq.delete();
    @(posedge clk);
    #1;
    chk("mrst_we_n", 32'(sram_we_n), 32'h1);
    chk("mrst_oe", 32'(sram_dq_oe), 32'h0);
    chk("mrst_rdata", read_data, 32'h0);
    chk("mrst_addr", 32'(sram_addr), 32'h0);
    rst = 1'b1;
    chk("mrst_mem4", 32'(mem[4]), 32'hCCDD);
    chk("mrst_mem5", 32'(mem[5]), 32'h0);
    issue(1'b1, 1'b0, 32'd1032, 32'h0, 32'h0000CCDD);
    wait_done();
    idle();

`ifdef MEM_SRAM_ALIGN_CHECK_EN
    chk("al_clear", 32'(align_err), 32'h0);
    issue(1'b0, 1'b1, 32'd1026, 32'h55AA1234, 32'h0);
    wait_done();
    idle();
    chk("al_set", 32'(align_err), 32'h1);
    chk("al_mem0", 32'(mem[0]), 32'h1234);
    chk("al_mem1", 32'(mem[1]), 32'h55AA);
    issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'h55AA1234);
    wait_done();
    idle();
    chk("al_sticky", 32'(align_err), 32'h1);
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
